// File: rtl/i2c_pkg.sv
// Shared I2C definitions: FSM states, ACK levels, byte width, address helper.
package i2c_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    ADDR_ACK,
    WR_DATA,
    WR_ACK,
    RD_DATA,
    RD_ACK,
    IGNORE
  } i2c_state_t;

  localparam logic I2C_ACK   = 1'b0;
  localparam logic I2C_NACK  = 1'b1;
  localparam int   BYTE_BITS = 8;

  // General call (address 0) is never claimed.
  function automatic logic addr_match(input logic [6:0] addr, input logic [6:0] own);
    return (addr == own) && (addr != 7'd0);
  endfunction

endpackage

// File: rtl/i2c_bus_sync.sv
// Synchronizes SCL/SDA into clk and derives SCL edges and START/STOP events.
module i2c_bus_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic scl_in,
  input  logic sda_in,
  output logic scl_rise,
  output logic scl_fall,
  output logic start_det,
  output logic stop_det,
  output logic sda_s
);

  logic [SYNC_STAGES-1:0] scl_sync;
  logic [SYNC_STAGES-1:0] sda_sync;
  logic                   scl_s;
  logic                   scl_d;
  logic                   sda_d;

  // Synchronizer chains plus one delayed copy; reset to the idle-bus level so
  // leaving reset never fabricates an edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scl_sync <= '1;
      sda_sync <= '1;
      scl_d    <= 1'b1;
      sda_d    <= 1'b1;
    end else begin
      scl_sync <= {scl_sync[SYNC_STAGES-2:0], scl_in};
      sda_sync <= {sda_sync[SYNC_STAGES-2:0], sda_in};
      scl_d    <= scl_s;
      sda_d    <= sda_s;
    end
  end

  assign scl_s     = scl_sync[SYNC_STAGES-1];
  assign sda_s     = sda_sync[SYNC_STAGES-1];
  assign scl_rise  = scl_s & ~scl_d;
  assign scl_fall  = ~scl_s & scl_d;
  assign start_det = scl_s & scl_d & sda_d & ~sda_s;
  assign stop_det  = scl_s & scl_d & ~sda_d & sda_s;

endmodule

// File: rtl/i2c_slave.sv
// I2C target: 7-bit address match, write bytes to rx_data, read bytes from tx_data.
// No clock stretching; all decisions use synchronized bus levels.
module i2c_slave
  import i2c_pkg::*;
#(
  parameter logic [6:0] SLAVE_ADDR  = 7'b1010000,
  parameter int         SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       scl_in,
  input  logic       sda_in,
  output logic       sda_oe,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic [7:0] tx_data,
  output logic       tx_req,
  output logic       busy
);

  localparam logic [2:0] LAST_BIT = 3'(BYTE_BITS - 1);

  logic scl_rise, scl_fall, start_det, stop_det, sda_s;

  i2c_bus_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk       (clk),
    .rst       (rst),
    .scl_in    (scl_in),
    .sda_in    (sda_in),
    .scl_rise  (scl_rise),
    .scl_fall  (scl_fall),
    .start_det (start_det),
    .stop_det  (stop_det),
    .sda_s     (sda_s)
  );

  i2c_state_t state, state_n;
  logic [7:0] shreg, shreg_n;
  logic [2:0] bit_cnt, bit_cnt_n;
  logic       rw, rw_n;
  logic       sda_oe_n;
  logic [7:0] rx_data_n;
  logic       rx_valid_n;
  logic       tx_req_n;
  logic       busy_n;

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      shreg    <= 8'h00;
      bit_cnt  <= 3'd0;
      rw       <= 1'b0;
      sda_oe   <= 1'b0;
      rx_data  <= 8'h00;
      rx_valid <= 1'b0;
      tx_req   <= 1'b0;
      busy     <= 1'b0;
    end else begin
      state    <= state_n;
      shreg    <= shreg_n;
      bit_cnt  <= bit_cnt_n;
      rw       <= rw_n;
      sda_oe   <= sda_oe_n;
      rx_data  <= rx_data_n;
      rx_valid <= rx_valid_n;
      tx_req   <= tx_req_n;
      busy     <= busy_n;
    end
  end

  // Next-state logic. START/STOP outrank SCL edges. The ACK phase is entered on
  // the 8th rise, drives SDA from the following fall, and is left on the ACK
  // rise so the next data state sees the ACK-ending fall as its first event.
  always_comb begin
    state_n    = state;
    shreg_n    = shreg;
    bit_cnt_n  = bit_cnt;
    rw_n       = rw;
    sda_oe_n   = sda_oe;
    rx_data_n  = rx_data;
    rx_valid_n = 1'b0;
    tx_req_n   = 1'b0;
    busy_n     = busy;

    // tx_data is captured in the cycle tx_req is high.
    if (tx_req) shreg_n = tx_data;

    if (stop_det) begin
      state_n   = IDLE;
      sda_oe_n  = 1'b0;
      busy_n    = 1'b0;
      bit_cnt_n = 3'd0;
    end else if (start_det) begin
      state_n   = ADDR;
      sda_oe_n  = 1'b0;
      bit_cnt_n = 3'd0;
    end else begin
      case (state)
        ADDR: begin
          if (scl_rise) begin
            shreg_n   = {shreg[6:0], sda_s};
            bit_cnt_n = bit_cnt + 3'd1;
            if (bit_cnt == LAST_BIT) begin
              if (addr_match(shreg[6:0], SLAVE_ADDR)) begin
                state_n = ADDR_ACK;
                rw_n    = sda_s;
                busy_n  = 1'b1;
              end else begin
                state_n = IGNORE;
                busy_n  = 1'b0;
              end
            end
          end
        end
        ADDR_ACK: begin
          if (scl_fall) begin
            sda_oe_n = 1'b1;
          end else if (scl_rise) begin
            bit_cnt_n = 3'd0;
            if (rw) begin
              state_n  = RD_DATA;
              tx_req_n = 1'b1;
            end else begin
              state_n = WR_DATA;
            end
          end
        end
        WR_DATA: begin
          if (scl_fall) begin
            sda_oe_n = 1'b0;
          end else if (scl_rise) begin
            shreg_n   = {shreg[6:0], sda_s};
            bit_cnt_n = bit_cnt + 3'd1;
            if (bit_cnt == LAST_BIT) begin
              rx_data_n  = {shreg[6:0], sda_s};
              rx_valid_n = 1'b1;
              state_n    = WR_ACK;
            end
          end
        end
        WR_ACK: begin
          if (scl_fall) begin
            sda_oe_n = 1'b1;
          end else if (scl_rise) begin
            bit_cnt_n = 3'd0;
            state_n   = WR_DATA;
          end
        end
        RD_DATA: begin
          if (scl_fall) begin
            sda_oe_n = ~shreg[7];
            shreg_n  = {shreg[6:0], 1'b0};
          end else if (scl_rise) begin
            bit_cnt_n = bit_cnt + 3'd1;
            if (bit_cnt == LAST_BIT) state_n = RD_ACK;
          end
        end
        RD_ACK: begin
          if (scl_fall) begin
            sda_oe_n = 1'b0;
          end else if (scl_rise) begin
            bit_cnt_n = 3'd0;
            if (sda_s == I2C_ACK) begin
              state_n  = RD_DATA;
              tx_req_n = 1'b1;
            end else begin
              state_n = IGNORE;
            end
          end
        end
        default: begin
          sda_oe_n = 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_slave.sv
// Self-checking bench: bit-banged I2C master against a transaction-level model.
module tb_i2c_slave;
  import i2c_pkg::*;

  localparam logic [6:0] OWN = 7'h50;
  localparam int         Q   = 10;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       scl = 1'b1;
  logic       msda = 1'b1;
  logic [7:0] tx_data = 8'h00;
  logic       sda_oe, rx_valid, tx_req, busy;
  logic [7:0] rx_data;
  logic       sda_bus;

  int tests = 0;
  int failed = 0;

  int         rx_cnt = 0;
  int         txreq_cnt = 0;
  int         oe_cnt = 0;
  int         busy_cnt = 0;
  logic [7:0] rx_log [0:255];

  assign sda_bus = msda & ~sda_oe;

  always #5 clk = ~clk;

  i2c_slave #(.SLAVE_ADDR(OWN), .SYNC_STAGES(2)) dut (
    .clk      (clk),
    .rst      (rst),
    .scl_in   (scl),
    .sda_in   (sda_bus),
    .sda_oe   (sda_oe),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .tx_data  (tx_data),
    .tx_req   (tx_req),
    .busy     (busy)
  );

  // Monitor: record strobes and activity, sampled away from the active edge.
  always @(negedge clk) begin
    if (rx_valid) begin
      rx_log[rx_cnt[7:0]] = rx_data;
      rx_cnt = rx_cnt + 1;
    end
    if (tx_req) txreq_cnt = txreq_cnt + 1;
    if (sda_oe) oe_cnt = oe_cnt + 1;
    if (busy) busy_cnt = busy_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic qwait();
    repeat (Q) @(negedge clk);
  endtask

  task automatic clock_bit(input logic d, output logic s);
    msda = d;
    qwait();
    scl = 1'b1;
    qwait();
    s = sda_bus;
    qwait();
    scl = 1'b0;
    qwait();
  endtask

  task automatic write_byte(input logic [7:0] b, output logic ack);
    logic dummy;
    for (int i = 7; i >= 0; i--) clock_bit(b[i], dummy);
    clock_bit(1'b1, ack);
  endtask

  task automatic read_byte(input logic mack, output logic [7:0] b);
    logic dummy;
    for (int i = 7; i >= 0; i--) clock_bit(1'b1, b[i]);
    clock_bit(mack, dummy);
  endtask

  task automatic bus_start();
    msda = 1'b1;
    qwait();
    scl = 1'b1;
    qwait();
    msda = 1'b0;
    qwait();
    scl = 1'b0;
    qwait();
  endtask

  task automatic bus_stop();
    msda = 1'b0;
    qwait();
    scl = 1'b1;
    qwait();
    msda = 1'b1;
    qwait();
    qwait();
  endtask

  initial begin
    logic       ack, dummy;
    logic [7:0] b;
    int         r0, t0, o0, bz0;
    logic [6:0] addr;
    logic       rw, exp_match;
    int         nbytes;
    logic [7:0] txb [0:3];
    logic [7:0] exp_rx [0:3];

    // Reset values
    @(negedge clk);
    check("reset_sda_oe", sda_oe, 0);
    check("reset_rx_data", rx_data, 8'h00);
    check("reset_rx_valid", rx_valid, 0);
    check("reset_tx_req", tx_req, 0);
    check("reset_busy", busy, 0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    qwait();

    // Matched write
    r0 = rx_cnt;
    bus_start();
    write_byte(8'hA0, ack);
    check("wr_addr_ack", ack, I2C_ACK);
    check("wr_busy_mid", busy, 1);
    write_byte(8'h6A, ack);
    check("wr_data_ack", ack, I2C_ACK);
    check("wr_rx_count", rx_cnt - r0, 1);
    check("wr_rx_data", rx_log[r0[7:0]], 8'h6A);
    check("wr_busy_before_stop", busy, 1);
    bus_stop();
    check("wr_busy_after_stop", busy, 0);

    // Address mismatch
    r0 = rx_cnt; o0 = oe_cnt; bz0 = busy_cnt;
    bus_start();
    write_byte(8'hA2, ack);
    check("mm_addr_nack", ack, I2C_NACK);
    write_byte(8'h33, ack);
    check("mm_data_nack", ack, I2C_NACK);
    bus_stop();
    check("mm_oe_never", oe_cnt - o0, 0);
    check("mm_no_rx", rx_cnt - r0, 0);
    check("mm_busy_never", busy_cnt - bz0, 0);

    // Matched read
    t0 = txreq_cnt;
    tx_data = 8'hA5;
    bus_start();
    write_byte(8'hA1, ack);
    check("rd_addr_ack", ack, I2C_ACK);
    tx_data = 8'h3C;
    read_byte(I2C_ACK, b);
    check("rd_byte0", b, 8'hA5);
    read_byte(I2C_NACK, b);
    check("rd_byte1", b, 8'h3C);
    check("rd_txreq_count", txreq_cnt - t0, 2);
    check("rd_released_after_nack", sda_oe, 0);
    bus_stop();

    // Repeated START: write then read
    r0 = rx_cnt;
    bus_start();
    write_byte(8'hA0, ack);
    check("rs_wr_addr_ack", ack, I2C_ACK);
    write_byte(8'h11, ack);
    check("rs_wr_data_ack", ack, I2C_ACK);
    check("rs_rx_data", rx_log[r0[7:0]], 8'h11);
    tx_data = 8'h5A;
    bus_start();
    write_byte(8'hA1, ack);
    check("rs_rd_addr_ack", ack, I2C_ACK);
    read_byte(I2C_NACK, b);
    check("rs_rd_byte", b, 8'h5A);
    bus_stop();
    check("rs_busy_after_stop", busy, 0);

    // STOP after 4 bits of a data byte
    r0 = rx_cnt;
    bus_start();
    write_byte(8'hA0, ack);
    check("ms_addr_ack", ack, I2C_ACK);
    clock_bit(1'b1, dummy);
    clock_bit(1'b0, dummy);
    clock_bit(1'b1, dummy);
    clock_bit(1'b1, dummy);
    bus_stop();
    check("ms_no_rx", rx_cnt - r0, 0);
    check("ms_state_idle", dut.state, IDLE);
    check("ms_sda_oe", sda_oe, 0);
    check("ms_busy", busy, 0);

    // Reset during the address ACK
    bus_start();
    for (int i = 7; i >= 0; i--) clock_bit(((8'hA0 >> i) & 8'h01) != 0, dummy);
    check("rm_ack_driven", sda_oe, 1);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("rm_async_sda_oe", sda_oe, 0);
    check("rm_busy", busy, 0);
    check("rm_rx_data", rx_data, 8'h00);
    check("rm_rx_valid", rx_valid, 0);
    check("rm_tx_req", tx_req, 0);
    qwait();
    scl = 1'b1;
    qwait();
    msda = 1'b1;
    qwait();
    rst = 1'b0;
    qwait();
    r0 = rx_cnt;
    bus_start();
    write_byte(8'hA0, ack);
    check("rm_post_addr_ack", ack, I2C_ACK);
    write_byte(8'h42, ack);
    check("rm_post_data_ack", ack, I2C_ACK);
    bus_stop();
    check("rm_post_rx_count", rx_cnt - r0, 1);
    check("rm_post_rx_data", rx_log[r0[7:0]], 8'h42);

    // Randomized transactions against the transaction-level model
    for (int t = 0; t < 12; t++) begin
      if ($urandom_range(0, 2) != 0) addr = OWN;
      else begin
        addr = 7'($urandom_range(0, 127));
        if (addr == OWN) addr = 7'h00;
      end
      rw        = 1'($urandom_range(0, 1));
      nbytes    = $urandom_range(1, 3);
      exp_match = (addr == OWN) && (addr != 7'h00);
      for (int k = 0; k < 4; k++) txb[k] = 8'($urandom_range(0, 255));
      r0 = rx_cnt; t0 = txreq_cnt;

      tx_data = txb[0];
      bus_start();
      write_byte({addr, rw}, ack);
      check("rnd_addr_ack", ack, exp_match ? I2C_ACK : I2C_NACK);
      if (!rw) begin
        for (int k = 0; k < nbytes; k++) begin
          exp_rx[k] = txb[k];
          write_byte(txb[k], ack);
          check("rnd_wr_ack", ack, exp_match ? I2C_ACK : I2C_NACK);
        end
        check("rnd_wr_count", rx_cnt - r0, exp_match ? nbytes : 0);
        if (exp_match)
          for (int k = 0; k < nbytes; k++)
            check("rnd_wr_data", rx_log[8'(r0 + k)], exp_rx[k]);
      end else begin
        tx_data = txb[1];
        for (int k = 0; k < nbytes; k++) begin
          read_byte((k == nbytes - 1) ? I2C_NACK : I2C_ACK, b);
          check("rnd_rd_data", b, exp_match ? txb[k] : 8'hFF);
          tx_data = txb[(k + 2) % 4];
        end
        check("rnd_rd_txreq", txreq_cnt - t0, exp_match ? nbytes : 0);
      end
      bus_stop();
      check("rnd_busy_after_stop", busy, 0);
      check("rnd_oe_after_stop", sda_oe, 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/i2c_slave.md
# i2c_slave

Synthesizable I2C target (responder) that answers the `i2c_master` across the board-level SCL/SDA pair. It detects START and STOP conditions and matches a 7-bit address. It ACKs and delivers received write bytes to the downstream data path (e.g. the filter input), and serves read bytes supplied by local logic. It uses 7-bit addressing, standard/fast-mode timing, and performs no clock stretching.

## Interface
- `SLAVE_ADDR`, default `7'b1010000`, device address compared against the address byte.
- `SYNC_STAGES`, default `2`, synchronizer depth on SCL/SDA inputs (minimum 2).
- `clk` in 1: system clock, at least 8× the SCL frequency.
- `rst` in 1: asynchronous, active-high reset.
- `scl_in` in 1: SCL bus level.
- `sda_in` in 1: SDA bus level.
- `sda_oe` out 1: open-drain SDA pull-down; 1 drives SDA low, 0 releases it.
- `rx_data` out 8: last byte received in a write transfer.
- `rx_valid` out 1: single-cycle strobe; `rx_data` is valid in that cycle.
- `tx_data` in 8: byte to return on a read; sampled when `tx_req` is high.
- `tx_req` out 1: single-cycle strobe; `tx_data` is captured in that same cycle.
- `busy` out 1: high from an address match until STOP, or until a START that does not match.

## Operation
- **Input conditioning:** SCL and SDA pass through `SYNC_STAGES` flops, then one more registered copy for edge detection.
- **Bus events:**
  - START: SDA falls while SCL is high.
  - STOP: SDA rises while SCL is high.
  - SCL rise/fall: edges of the synced SCL.
- **Bit sampling:** data bits are sampled on SCL rise, MSB first. `sda_oe` changes only on SCL fall, one clk after detection.
- **States:**
  - IDLE: START → ADDR.
  - ADDR: shift 8 bits (7 address + R/W). On the 8th SCL rise, on a match go to ADDR_ACK; on a mismatch go to IGNORE.
  - ADDR_ACK: `sda_oe=1` from the next SCL fall to the following SCL fall. Then R/W=0 → WR_DATA; R/W=1 → RD_DATA.
  - WR_DATA: shift 8 bits. On the 8th SCL rise, load `rx_data` and pulse `rx_valid`, then go to WR_ACK.
  - WR_ACK: ACK as in ADDR_ACK, then → WR_DATA.
  - RD_DATA: pulse `tx_req` and load the shift register on entry. Drive `sda_oe = ~bit` on each SCL fall, with bit 7 placed on the SCL fall that ends the ACK. After the 8th bit's SCL fall, release SDA → RD_ACK.
  - RD_ACK: sample SDA on SCL rise. Low (ACK) → RD_DATA with a new `tx_req`; high (NACK) → IGNORE.
  - IGNORE: `sda_oe=0`, wait for START or STOP.
- **STOP in any state:** go to IDLE, `sda_oe=0`, `busy=0`. A partial byte is discarded and `rx_valid` does not fire.
- **START in any non-IDLE state (repeated START):** go to ADDR, bit counter cleared, `sda_oe` released.
- **Bit counter:** 3 bits; it wraps after 8 and is cleared on START and on each ACK phase.
- **General call (address 0):** not acknowledged.

## Timing
- **Reset values:** `sda_oe=0`, `rx_data=8'h00`, `rx_valid=0`, `tx_req=0`, `busy=0`, state IDLE, shift register 0.
- **Sync latency:** an input change is seen `SYNC_STAGES+1` clk after the bus change. All bus-event decisions use synced values only.
- **`rx_valid`:** asserted 1 clk after the 8th data-bit SCL rise is detected, for exactly 1 clk.
- **`tx_req`:** asserted 1 clk after the ACK-phase SCL rise is detected, for exactly 1 clk. `tx_data` must be stable in that cycle.
- **ACK release:** `sda_oe` deasserts within 1 clk of the SCL fall that ends the ACK bit.
- **`busy`:** rises 1 clk after the address-match decision and falls 1 clk after STOP detection.
- **Priority within one clk:** STOP/START outrank SCL edge handling. `rst` overrides everything, asynchronously.

## Structure
- **Package `i2c_pkg`:** state enum (IDLE, ADDR, ADDR_ACK, WR_DATA, WR_ACK, RD_DATA, RD_ACK, IGNORE), `I2C_ACK=1'b0`, `I2C_NACK=1'b1`, `BYTE_BITS=8`. Share it with `i2c_master`.
- **Sub-module `i2c_bus_sync`:** synchronizers plus outputs `scl_rise`, `scl_fall`, `start_det`, `stop_det`, `sda_s`. Instantiate it once.
- **Top level:** the FSM, shift register, bit counter and output registers live in `i2c_slave`.

## Test plan
- **Matched write:** START, byte 0xA0 (addr 0x50, W), byte 0x6A, STOP.
  - Required: ACK low on both ninth clocks.
  - Required: exactly one `rx_valid` with `rx_data=0x6A`.
  - Required: `busy` 1 until STOP, then 0.
- **Address mismatch:** START, byte 0xA2 (addr 0x51), byte 0x33, STOP.
  - Required: `sda_oe` never asserted, no `rx_valid`, `busy` stays 0.
- **Matched read:** START, byte 0xA1, `tx_data=0xA5`, master ACKs, `tx_data=0x3C`, master NACKs, STOP.
  - Required: bits 1,0,1,0,0,1,0,1 then 0,0,1,1,1,1,0,0.
  - Required: two `tx_req` pulses, and SDA released after the NACK.
- **Repeated START:** write 0xA0, byte 0x11, repeated START, byte 0xA1, read with `tx_data=0x5A`, NACK, STOP.
  - Required: `rx_data=0x11`, then 0x5A shifted out.
- **STOP mid-byte:** STOP after 4 bits of a data byte.
  - Required: no `rx_valid`, state IDLE, `sda_oe=0`.
- **Reset mid-transfer:** assert `rst` during ADDR_ACK while `sda_oe=1`.
  - Required: `sda_oe` drops to 0 with no clock edge needed; all outputs return to their reset values.
  - Required: a following full write of 0x42 completes normally.
